// File: rtl/reg16_rr_arbiter_pkg.sv
// rtl/reg16_rr_arbiter_pkg.sv - shared types, constants and helpers for the shared-register arbiter
package reg16_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int CNT_W = 4;

  // Index width for N requesters; never returns 0 so N=1 builds still get a 1-bit field.
  function automatic int clog2_n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg16_rr_arbiter_if.sv
// rtl/reg16_rr_arbiter_if.sv - requester/arbiter bundle for the shared 16-bit register
interface reg16_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  import reg16_arb_pkg::*;

  localparam int OW = clog2_n(N);

  logic [N-1:0]       req;
  logic [N-1:0]       last;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic [OW-1:0]      owner;
  logic               busy;

  modport master (
    output req, last, wdata,
    input  gnt, q, owner, busy
  );

  modport slave (
    input  req, last, wdata,
    output gnt, q, owner, busy
  );

endinterface

// File: rtl/reg16_rr_arbiter_rr_pick.sv
// rtl/reg16_rr_arbiter_rr_pick.sv - combinational round-robin picker starting the search at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Doubled vector lets the wrap-around search be a plain window starting at ptr.
  logic [2*N-2:0] dbl;

  always_comb begin
    dbl     = {req_i[N-2:0], req_i};
    found_o = 1'b0;
    idx_o   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (dbl[int'(ptr_i) + j]) begin
        found_o = 1'b1;
        if (int'(ptr_i) + j >= N) idx_o = IW'(int'(ptr_i) + j - N);
        else                      idx_o = IW'(int'(ptr_i) + j);
      end
    end
  end

endmodule

// File: rtl/reg16_rr_arbiter.sv
// rtl/reg16_rr_arbiter.sv - round-robin write-ownership arbiter and burst sequencer for one shared register
module reg16_rr_arbiter
  import reg16_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst,
  reg16_rr_arbiter_if.slave  bus
);

  localparam int OW = clog2_n(N);

  arb_state_e       state_q;
  logic [N-1:0]     gnt_q;
  logic [WIDTH-1:0] q_q;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    ptr_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic [N-1:0]     gnt_d;
  logic [OW-1:0]    ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] wsel;
  logic             req_own;
  logic             last_own;
  logic             burst_end;

  rr_pick #(.N(N), .IW(OW)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    req_own   = bus.req[owner_q];
    last_own  = bus.last[owner_q];
    wsel      = bus.wdata[owner_q*WIDTH +: WIDTH];
    cnt_d     = cnt_q + 1'b1;
    // A dropped request ends the burst without a write; last or the cap end it after the write.
    burst_end = !req_own || last_own || (cnt_q == CNT_W'(MAX_BURST - 1));
    ptr_d     = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
    gnt_d     = '0;
    gnt_d[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q   <= gnt_d;
            owner_q <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (req_own) q_q <= wsel;
          cnt_q <= burst_end ? '0 : cnt_d;
          if (burst_end) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.q     = q_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/reg16_rr_arbiter.md
# reg16_rr_arbiter

- Round-robin arbiter and write sequencer for one shared 16-bit data register.
- Up to N requesters compete for write ownership. The winner holds a grant for a bounded burst of writes, then ownership rotates.
- Sits between the requesting datapath units and the shared register. It provides the registered value `q` and current-owner status to downstream logic.

## Interface
- N, 4, number of requesters (2..8)
- WIDTH, 16, register/data width
- MAX_BURST, 4, max writes per ownership (1..15)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (low = reset asserted)
- req  input  N  request per requester; held high while it wants to write
- last  input  N  requester marks its current write as the final one of its burst
- wdata  input  N*WIDTH  write data; slice i = wdata[i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant, registered
- q  output  WIDTH  shared register contents
- owner  output  $clog2(N)  index of current/most recent owner
- busy  output  1  high while in OWN state

## Operation
- Reset (rst low, async):
  - gnt=0, q=0, owner=0, busy=0
  - internal rotate pointer ptr=0, burst count=0, state IDLE
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, …, wrapping mod N.
  - Next edge: gnt[i]=1, owner=i, count=0, state OWN, busy=1.
- State OWN (owner i):
  - Each edge with req[i]=1: q<=wdata slice i, count<=count+1.
  - Burst ends at the edge where any of these holds:
    - req[i]=0: no write that cycle.
    - req[i]=1 and last[i]=1: the write happens.
    - req[i]=1 and count==MAX_BURST-1: the write happens, so MAX_BURST writes total.
  - On burst end, at the same edge: gnt=0, busy=0, ptr<=(i+1) mod N, state IDLE. owner holds i.
- Fairness: after owning, a requester has the lowest priority. Each of the N requesters waits at most N-1 bursts.
- Non-owner req/last/wdata are ignored. last[i] without req[i] is ignored.
- Writes occur only in OWN. q holds its value otherwise.

## Timing
- Grant latency: req seen high at edge k in IDLE → gnt high after edge k. First possible write at edge k+1.
- Always exactly one IDLE cycle between consecutive owners, even with continuous requests. The gnt one-hot index changes only across that gap.
- Back-to-back continuous requesters: max throughput MAX_BURST writes per MAX_BURST+1 cycles.
- gnt is never multi-hot. busy == |gnt at all times.
- count width 4 bits. count never exceeds MAX_BURST-1.
- Reset mid-burst:
  - Outputs clear immediately, without waiting for clk.
  - After release, arbitration restarts from ptr=0 on the first edge with rst high.
- A req rising at the same edge a burst ends is seen in the following IDLE cycle. The pointer has already advanced.

## Structure
- Shared package `reg16_arb_pkg`:
  - State enum IDLE/OWN.
  - Constant for count width (4).
  - Function `clog2_n`.
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: req[N-1:0] and ptr. Outputs: found and idx.
  - Implemented as a doubled-vector priority search.
- The top level holds FSM, counter, pointer, q register and grant register.

## Test plan
- Reset: rst=0 with req=4'b1111, wdata all nonzero → gnt=0, q=16'h0000, busy=0. Then release rst → gnt=4'b0001 after the first edge.
- Single burst: req[2]=1, wdata2=16'hAAAA, then 16'h5555, with last[2] on the 2nd write → q=AAAA then 5555. gnt=4'b0100 for exactly 2 cycles, then 0. owner=2.
- Burst cap: req[0] held high, last=0, wdata0 incrementing from 16'h0001 → exactly 4 writes, q ends at 16'h0004, then gnt drops for one cycle.
- Rotation: req=4'b1111 continuous → grant order 0,1,2,3,0, each 4 writes. One IDLE cycle between owners. gnt always one-hot.
- Early drop and ignore: owner 1 drops req after 1 write while req[3]=1 with wdata3=16'hF0F0 → req[3]'s data is ignored during owner 1's burst, q keeps owner 1's value. Next grant goes to 3.
- Async reset mid-burst: assert rst low between edges during OWN with q=16'hF0F0 → q=0 and gnt=0 immediately. After release, arbitration restarts from requester 0.
